pic_host_bus_master: RTL and testbench

Synchronous CPU-side bus initiator for the 8259A-compatible PIC in this design. It sequences CS/WR/RD/A0 and the 8-bit system data bus to run the ICW1→ICW2→[ICW3]→[ICW4] initialization, then issues OCW writes and status reads on request through a valid/ready command port. It sits between the host/testbench command source and the PIC's read/write logic, and is the writer/reader counterpart of that logic.

---
 rtl/pic_host_bus_master.sv | 107 ++++++++++
 tb/tb_pic_host_bus_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_host_bus_master.sv
// pic_host_bus_master: 8259A bus initiator running ICW1..ICW4 init then OCW/status accesses; ports: start/icw1-4 init, cmd_* valid/ready port, rd_data/rd_valid, init_done/busy, CS/WR/RD/A0 strobes, sys_bus tristate
module pic_host_bus_master #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       init_done,
  output logic       busy,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       A0,
  inout  wire  [7:0] sys_bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;
  localparam logic [7:0] S_L = 8'(SETUP_CYC - 1);
  localparam logic [7:0] P_L = 8'(PULSE_CYC - 1);
  localparam logic [7:0] H_L = 8'(HOLD_CYC - 1);
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx, cur_data, w2, w3, w4;
  logic [1:0] idx, nxt;
  logic seq, no_icw3, has_icw4, cur_rd, cur_a0, more, last, act, go_init, go_cmd, rd_cap;
  assign go_init   = start && state == IDLE;
  assign cmd_ready = init_done && state == IDLE && !start;
  assign go_cmd    = cmd_valid && cmd_ready;
  assign last      = cnt == 8'd0;
  assign rd_cap    = state == STROBE && last && cur_rd;
  assign nxt       = idx == 2'd0 ? 2'd1 : (idx == 2'd1 && !no_icw3) ? 2'd2 : 2'd3;
  assign more      = seq && (idx == 2'd0 || (idx == 2'd1 && (!no_icw3 || has_icw4)) || (idx == 2'd2 && has_icw4));
  assign act       = state == SETUP || state == STROBE || state == HOLD;
  assign busy      = state != IDLE;
  assign CS        = !act;
  assign WR        = !(state == STROBE && !cur_rd);
  assign RD        = !(state == STROBE && cur_rd);
  assign A0        = act && cur_a0;
  assign sys_bus   = (act && !cur_rd) ? cur_data : 8'hzz;
  always_comb begin
    state_nx = state;
    cnt_nx   = last ? cnt : cnt - 8'd1;
    if (state == IDLE) begin
      state_nx = (go_init || go_cmd) ? SETUP : IDLE;
      cnt_nx   = (go_init || go_cmd) ? S_L : cnt;
    end else if (last) begin
      state_nx = state == SETUP ? STROBE : state == STROBE ? HOLD : state == HOLD ? GAP : more ? SETUP : IDLE;
      cnt_nx   = state == SETUP ? P_L : state == STROBE ? H_L : state == HOLD ? 8'd0 : S_L;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      idx       <= 2'd0;
      seq       <= 1'b0;
      no_icw3   <= 1'b0;
      has_icw4  <= 1'b0;
      w2        <= 8'd0;
      w3        <= 8'd0;
      w4        <= 8'd0;
      cur_rd    <= 1'b0;
      cur_a0    <= 1'b0;
      cur_data  <= 8'd0;
      rd_data   <= 8'd0;
      rd_valid  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rd_valid <= rd_cap;
      if (rd_cap) rd_data <= sys_bus;
      if (go_init) begin
        {no_icw3, has_icw4} <= icw1[1:0];
        {w2, w3, w4}        <= {icw2, icw3, icw4};
        idx       <= 2'd0;
        seq       <= 1'b1;
        init_done <= 1'b0;
        cur_rd    <= 1'b0;
        cur_a0    <= 1'b0;
        cur_data  <= icw1 | 8'h10;
      end else if (go_cmd) begin
        cur_rd   <= cmd_rd;
        cur_a0   <= cmd_a0;
        cur_data <= cmd_data;
      end else if (state == GAP && more) begin
        idx      <= nxt;
        cur_a0   <= 1'b1;
        cur_data <= nxt == 2'd1 ? w2 : nxt == 2'd2 ? w3 : w4;
      end else if (state == GAP && seq) begin
        seq       <= 1'b0;
        init_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pic_host_bus_master.sv
// tb_pic_host_bus_master: directed checks of init sequencing, command port, reads and async reset
module tb_pic_host_bus_master;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cmd_valid = 1'b0, cmd_rd = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00, cmd_data = 8'h00;
  logic cmd_ready, rd_valid, init_done, busy, CS, WR, RD, A0;
  logic [7:0] rd_data, pic_drv = 8'h00, rbus;
  logic pic_en = 1'b0;
  logic [4:0] vpat;
  wire [7:0] sys_bus;
  assign sys_bus = pic_en ? pic_drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (sys_bus[g]);
  end
  pic_host_bus_master dut (
    .clk(clk), .reset(reset), .start(start), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done), .busy(busy),
    .CS(CS), .WR(WR), .RD(RD), .A0(A0), .sys_bus(sys_bus)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int nw = 0, wr_lo = 0, nr = 0, rd_lo = 0, rd_len_last = 0, rv_cnt = 0;
  logic [7:0] lg_d [64];
  logic lg_a0 [64];
  int lg_len [64];
  always @(negedge clk) begin
    if (!WR && !CS) begin
      if (wr_lo == 0 && nw < 64) begin
        lg_a0[nw] = A0;
        lg_d[nw] = sys_bus;
      end
      wr_lo++;
    end else if (wr_lo != 0) begin
      if (nw < 64) lg_len[nw] = wr_lo;
      nw++;
      wr_lo = 0;
    end
    if (!RD && !CS) rd_lo++;
    else if (rd_lo != 0) begin
      rd_len_last = rd_lo;
      nr++;
      rd_lo = 0;
    end
    if (rd_valid) rv_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_wr(input string tag, input int i, input logic a0, input logic [7:0] d);
    chk(tag, {15'd0, lg_a0[i], lg_d[i], lg_len[i][7:0]}, {15'd0, a0, d, 8'd2});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    {icw1, icw2, icw3, icw4} = {a, b, c, d};
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_init(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!init_done && n < 100);
  endtask
  task automatic do_cmd(input logic rd, input logic a0, input logic [7:0] d, output int n);
    @(negedge clk);
    {cmd_valid, cmd_rd, cmd_a0, cmd_data} = {1'b1, rd, a0, d};
    tick();
    cmd_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_ready && n < 50);
  endtask
  initial begin
    int n, seen, base, rbase;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {CS, WR, RD, A0}, 4'b1110);
    chk("rst_bus", sys_bus, 8'hFF);
    chk("rst_flags", {init_done, busy, cmd_ready, rd_valid}, 4'b0000);
    chk("rst_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    {cmd_valid, cmd_rd, cmd_a0, cmd_data} = {1'b1, 1'b0, 1'b1, 8'hFB};
    seen = 0;
    repeat (10) begin
      tick();
      if (cmd_ready || busy || !CS) seen++;
    end
    chk("pre_init_accept", seen, 0);
    cmd_valid = 1'b0;
    base = nw;
    do_start(8'h13, 8'h20, 8'h77, 8'h01);
    chk("initA_busy", {busy, init_done}, 2'b10);
    n = 0;
    do begin
      start = (n == 2);
      tick();
      n++;
    end while (!init_done && n < 100);
    start = 1'b0;
    chk("initA_latency", n, 15);
    chk("initA_count", nw - base, 3);
    chk_wr("initA_icw1", base, 1'b0, 8'h13);
    chk_wr("initA_icw2", base + 1, 1'b1, 8'h20);
    chk_wr("initA_icw4", base + 2, 1'b1, 8'h01);
    chk("initA_idle_bus", {busy, CS, sys_bus}, {1'b0, 1'b1, 8'hFF});
    base = nw;
    @(negedge clk);
    {cmd_valid, cmd_rd, cmd_a0, cmd_data} = {1'b1, 1'b0, 1'b1, 8'hFB};
    #1 chk("ocw1_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_ready && n < 50);
    chk("ocw1_ready_low", n, 5);
    chk("ocw1_count", nw - base, 1);
    chk_wr("ocw1_write", base, 1'b1, 8'hFB);
    do_cmd(1'b0, 1'b0, 8'h0A, n);
    chk("ocw3_cycles", n, 5);
    chk_wr("ocw3_write", base + 1, 1'b0, 8'h0A);
    base = nw;
    rbase = nr;
    seen = rv_cnt;
    {pic_en, pic_drv} = {1'b1, 8'h84};
    @(negedge clk);
    {cmd_valid, cmd_rd, cmd_a0, cmd_data} = {1'b1, 1'b1, 1'b0, 8'h5A};
    tick();
    cmd_valid = 1'b0;
    rbus = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      vpat[i] = rd_valid;
      if (i == 0) rbus = sys_bus;
    end
    pic_en = 1'b0;
    chk("rd_valid_timing", vpat, 5'b00100);
    chk("rd_data", rd_data, 8'h84);
    chk("rd_bus_undriven", rbus, 8'h84);
    chk("rd_strobe", {nr - rbase, rd_len_last, nw - base, rv_cnt - seen}, {32'd1, 32'd2, 32'd0, 32'd1});
    base = nw;
    @(negedge clk);
    {icw1, icw2, icw3, icw4} = {8'h00, 8'h40, 8'h04, 8'hEE};
    {start, cmd_valid, cmd_rd, cmd_a0, cmd_data} = {1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    #1 chk("collide_ready", cmd_ready, 1'b0);
    tick();
    start = 1'b0;
    chk("collide_init_clr", {init_done, busy}, 2'b01);
    wait_init(n);
    chk("initB_latency", n, 15);
    chk("initB_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_ready && n < 50);
    chk("collide_cmd_cycles", n, 5);
    chk("initB_count", nw - base, 4);
    chk_wr("initB_icw1", base, 1'b0, 8'h10);
    chk_wr("initB_icw2", base + 1, 1'b1, 8'h40);
    chk_wr("initB_icw3", base + 2, 1'b1, 8'h04);
    chk_wr("collide_cmd", base + 3, 1'b1, 8'h11);
    @(negedge clk);
    {cmd_valid, cmd_rd, cmd_a0, cmd_data} = {1'b1, 1'b0, 1'b1, 8'h33};
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_strobe", {CS, WR, sys_bus}, {2'b00, 8'h33});
    reset = 1'b1;
    #1;
    chk("mid_rst_strobes", {CS, WR, RD}, 3'b111);
    chk("mid_rst_bus", sys_bus, 8'hFF);
    chk("mid_rst_flags", {busy, init_done, cmd_ready}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = nw;
    do_start(8'h13, 8'h20, 8'h77, 8'h01);
    wait_init(n);
    chk("initC_latency", n, 15);
    chk("initC_count", nw - base, 3);
    chk_wr("initC_icw1", base, 1'b0, 8'h13);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
